// File: rtl/motion_sequencer.sv
`default_nettype none
// ============================================================================
// motion_sequencer : FIFO-fed motion command sequencer (IDLE/RUN/SETTLE/DONE)
// Optional post-move settle phase: define MOTION_SEQ_SETTLE_EN.  Rev 1.0
// ============================================================================
module motion_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    input  logic       tick,
    input  logic       abort,
    output logic       motor_en,
    output logic       motor_dir,
    output logic       turn_mode,
    output logic       curve,
    output logic [6:0] remaining,
    output logic [4:0] fifo_count,
    output logic       busy,
    output logic       done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_param_check
        $error("motion_sequencer: parameter out of range");
    end

`ifdef MOTION_SEQ_SETTLE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SETTLE = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [9:0]       queue_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [9:0]       head;
    logic             push;
    logic             pop;
    logic             last_tick;

    assign cmd_ready = (fifo_count < 5'(FIFO_DEPTH));
    assign head      = queue_mem[rd_ptr];
    assign push      = cmd_valid && cmd_ready && !abort;
    assign pop       = (state == IDLE) && (fifo_count != 5'd0) && !abort;
    assign last_tick = (state == RUN) && tick && (remaining == 7'd1);
    assign busy      = (state != IDLE) || (fifo_count != 5'd0);
    assign done      = (state == DONE);

`ifdef MOTION_SEQ_SETTLE_EN
    logic [7:0] settle_cnt;
    logic       settle_end;

    assign settle_end = (settle_cnt == 8'(SETTLE_CYCLES - 1));

    // Counter sits at zero outside SETTLE, so it counts cycles spent in SETTLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= 8'd0;
        end else if (abort || state != SETTLE) begin
            settle_cnt <= 8'd0;
        end else begin
            settle_cnt <= settle_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state_next = (head[6:0] == 7'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (last_tick) begin
`ifdef MOTION_SEQ_SETTLE_EN
                        state_next = SETTLE;
`else
                        state_next = DONE;
`endif
                    end
                end
`ifdef MOTION_SEQ_SETTLE_EN
                SETTLE: begin
                    if (settle_end) begin
                        state_next = DONE;
                    end
                end
`endif
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            motor_en  <= 1'b0;
            motor_dir <= 1'b0;
            turn_mode <= 1'b0;
            curve     <= 1'b0;
            remaining <= 7'd0;
        end else if (abort) begin
            motor_en  <= 1'b0;
            remaining <= 7'd0;
        end else if (pop) begin
            motor_dir <= head[9];
            turn_mode <= head[8];
            curve     <= head[7];
            remaining <= head[6:0];
            motor_en  <= (head[6:0] != 7'd0);
        end else if (state == RUN && tick && remaining != 7'd0) begin
            remaining <= remaining - 7'd1;
            if (last_tick) begin
                motor_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 5'd0;
        end else if (abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + {4'd0, push} - {4'd0, pop};
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[wr_ptr] <= cmd_data;
        end
    end

endmodule
`default_nettype wire
